text_update_ctrl: RTL and testbench
===================================

Name: text_update_ctrl

Overview:
- Frame-synchronous controller for the 8-character text line (8 x 4-bit character codes) and the 6-bit displayed value that feed the character ROM renderer.
- Arbitrates character writes from two requesters into a shadow line buffer and commits the shadow to the displayed line only on `newframe`, so the display never tears.
- Also generates the displayed value: a frame-paced counter that replaces the free-running clock-count prescaler.
- Runs in the 25 MHz pixel-clock domain, alongside the VGA timing generator.

Parameters:
- NCHAR, 8, number of characters in the line (index width is 3).
- CW, 4, character code width in bits.
- INIT_LINE, 32'hEEDA_EECB, reset contents of the shadow and displayed line ("FIZZBUZZ", char 0 in [3:0]).
- TICK_FRAMES, 30, number of `newframe` pulses per value increment (legal range 1..255).
- VAL_W, 6, width of the value counter.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- newframe  in  1  one-cycle pulse from the timing generator at frame start.
- hold  in  1  1 = freeze the value counter (frame count also frozen).
- req0  in  1  requester 0 write request.
- idx0  in  3  requester 0 character index.
- code0  in  4  requester 0 character code.
- ack0  out  1  one-cycle grant/accept pulse to requester 0.
- req1  in  1  requester 1 write request.
- idx1  in  3  requester 1 character index.
- code1  in  4  requester 1 character code.
- ack1  out  1  one-cycle grant/accept pulse to requester 1.
- line_out  out  32  displayed line, char i in [4i+3:4i].
- value_out  out  6  displayed value.
- commit  out  1  one-cycle pulse: `line_out` was updated on this cycle.
- dirty  out  1  shadow differs from `line_out` (a write is pending commit).

Behaviour:
- Reset (`rst`=0 at a clk edge):
  - shadow = line_out = INIT_LINE.
  - value_out = 0, frame count = 0.
  - ack0 = ack1 = commit = dirty = 0.
  - Priority pointer = requester 0.
  - Reset mid-operation discards pending writes; any held req is re-serviced after reset is released.
- Handshake:
  - A requester raises req with idx/code stable and holds them until it sees ack.
  - ack is registered: it asserts the cycle after the grant decision and stays high exactly 1 cycle.
  - The requester may drop req or present a new write in the cycle ack is seen.
  - The controller ignores a req that is still high during its own ack cycle, so no double-write occurs.
  - Max one grant per cycle.
  - Throughput per requester is one write every 2 cycles; aggregate throughput is one write per cycle.
- Arbitration:
  - Round-robin. If only one req is eligible, it wins.
  - If both are eligible, the priority-pointer requester wins, and the pointer then moves to the other requester.
  - The pointer is updated only on a contested grant.
- Write:
  - A granted write updates shadow[idx] <= code in the same edge that registers ack.
  - It also sets dirty <= 1.
- Commit FSM, states CLEAN and DIRTY:
  - CLEAN: on a write, go to DIRTY. On newframe, stay in CLEAN with no commit.
  - DIRTY: on newframe, line_out <= shadow (value before any write in the same cycle) and commit = 1 on the next cycle.
    - Go to CLEAN, unless a write is granted in the same cycle; then stay in DIRTY. That write appears in the following frame.
  - Commit latency: line_out changes on the edge that samples newframe; commit is high during the following cycle.
- Value counter:
  - On newframe with hold = 0: if frame count == TICK_FRAMES-1, frame count <= 0 and value_out increments; otherwise frame count increments.
  - value_out wraps from 2^VAL_W-1 (63) to 0.
  - With hold = 1, both the frame count and value_out keep their values.
  - value_out changes only on newframe edges, never mid-frame.
- newframe is a single-cycle pulse, one per frame (timing-generator contract); back-to-back pulses are not expected.

Test Plan:
- Reset: hold rst low 3 cycles -> line_out = 32'hEEDA_EECB, value_out = 0, ack0/1/commit/dirty = 0; rst sampled only on clk edges.
- Single write + commit: req0 idx0 = 2 code0 = 4'hA -> ack0 pulses 1 cycle, dirty = 1, line_out unchanged. On the next newframe, line_out = 32'hEEDA_EACB, commit pulses once, dirty = 0.
- Contention round-robin: req0 and req1 held continuously (idx 0/1, codes 3/5) -> acks alternate 0, 1, 0, 1. No double ack while req is still high in its ack cycle. Shadow chars 0 = 3, 1 = 5.
- Write coincident with newframe in DIRTY: pending write of char 7 = 1, then char 6 = 2 granted in the newframe cycle -> line_out[31:28] = 1, [27:24] unchanged, dirty stays 1. Next newframe commits char 6 = 2.
- Value counter, TICK_FRAMES = 2: 128 newframe pulses -> value_out steps every 2 frames and wraps 63 -> 0 at the 128th pulse. hold = 1 over 10 pulses -> no change.
- Reset mid-operation: dirty = 1 with req1 held, assert rst -> INIT_LINE restored, dirty = 0. After release, req1 acked within 2 cycles.

Source files
------------

// File: rtl/text_update_ctrl.sv
// Arbitrates two character writers into a shadow line and commits it to the display on frame start.
// Also keeps the frame-paced display value. Acks are registered and last one cycle each.
module text_update_ctrl #(
    parameter int              NCHAR       = 8,
    parameter int              CW          = 4,
    parameter logic [NCHAR*CW-1:0] INIT_LINE = 32'hEEDA_EECB,
    parameter int              TICK_FRAMES = 30,
    parameter int              VAL_W       = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       newframe,
    input  logic                       hold,
    input  logic                       req0,
    input  logic [$clog2(NCHAR)-1:0]   idx0,
    input  logic [CW-1:0]              code0,
    output logic                       ack0,
    input  logic                       req1,
    input  logic [$clog2(NCHAR)-1:0]   idx1,
    input  logic [CW-1:0]              code1,
    output logic                       ack1,
    output logic [NCHAR*CW-1:0]        line_out,
    output logic [VAL_W-1:0]           value_out,
    output logic                       commit,
    output logic                       dirty
);
    localparam int IW = $clog2(NCHAR);
    localparam int LW = NCHAR * CW;
    localparam int FW = 8;

    typedef enum logic {CLEAN, DIRTY} state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     shadow_q, shadow_d;
    logic [LW-1:0]     line_q, line_d;
    logic [VAL_W-1:0]  val_q, val_d;
    logic [FW-1:0]     fcnt_q, fcnt_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              ptr_q, ptr_d;
    logic              commit_q, commit_d;

    logic              elig0, elig1, grant0, grant1, wr_en;
    logic [IW-1:0]     wr_idx;
    logic [CW-1:0]     wr_code;

    always_comb begin
        // A requester still high in its own ack cycle is holding stale data, so it is not eligible.
        elig0   = req0 & ~ack0_q;
        elig1   = req1 & ~ack1_q;
        grant0  = elig0 & (~elig1 | ~ptr_q);
        grant1  = elig1 & ~grant0;
        wr_en   = grant0 | grant1;
        wr_idx  = grant0 ? idx0 : idx1;
        wr_code = grant0 ? code0 : code1;

        ack0_d   = grant0;
        ack1_d   = grant1;
        ptr_d    = (elig0 & elig1) ? ~ptr_q : ptr_q;
        shadow_d = shadow_q;
        line_d   = line_q;
        commit_d = 1'b0;
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        val_d    = val_q;

        if (wr_en) begin
            shadow_d[wr_idx*CW +: CW] = wr_code;
        end

        case (state_q)
            CLEAN: begin
                if (wr_en) begin
                    state_d = DIRTY;
                end
            end
            DIRTY: begin
                // Commit takes the pre-write shadow; a same-cycle write waits for the next frame.
                if (newframe) begin
                    line_d   = shadow_q;
                    commit_d = 1'b1;
                    state_d  = wr_en ? DIRTY : CLEAN;
                end
            end
            default: state_d = CLEAN;
        endcase

        if (newframe && !hold) begin
            if (fcnt_q == FW'(TICK_FRAMES - 1)) begin
                fcnt_d = '0;
                val_d  = val_q + VAL_W'(1);
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= CLEAN;
            shadow_q <= INIT_LINE;
            line_q   <= INIT_LINE;
            val_q    <= '0;
            fcnt_q   <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            ptr_q    <= 1'b0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            line_q   <= line_d;
            val_q    <= val_d;
            fcnt_q   <= fcnt_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            ptr_q    <= ptr_d;
            commit_q <= commit_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign line_out  = line_q;
    assign value_out = val_q;
    assign commit    = commit_q;
    assign dirty     = (state_q == DIRTY);
endmodule

// File: tb/tb_text_update_ctrl.sv
// Bench for text_update_ctrl: directed steps then random traffic, checked against a behavioural model.
module tb_text_update_ctrl;
    localparam int TICK = 2;

    logic        clk = 1'b0;
    logic        rst, newframe, hold, req0, req1;
    logic [2:0]  idx0, idx1;
    logic [3:0]  code0, code1;
    logic        ack0, ack1, commit, dirty;
    logic [31:0] line_out;
    logic [5:0]  value_out;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    text_update_ctrl #(
        .NCHAR(8), .CW(4), .INIT_LINE(32'hEEDA_EECB), .TICK_FRAMES(TICK), .VAL_W(6)
    ) dut (
        .clk(clk), .rst(rst), .newframe(newframe), .hold(hold),
        .req0(req0), .idx0(idx0), .code0(code0), .ack0(ack0),
        .req1(req1), .idx1(idx1), .code1(code1), .ack1(ack1),
        .line_out(line_out), .value_out(value_out), .commit(commit), .dirty(dirty)
    );

    // Behavioural model: character arrays, a pending flag and a count of counted frames.
    logic [3:0]  m_sh [8];
    logic [3:0]  m_ln [8];
    bit          m_pend, m_a0, m_a1, m_ptr, m_cm;
    int          m_nf;
    logic [31:0] init_v = 32'hEEDA_EECB;

    function automatic logic [31:0] disp_line();
        logic [31:0] r;
        for (int i = 0; i < 8; i++) r[4*i +: 4] = m_ln[i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_step();
        bit e0, e1, g0, g1;
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                m_sh[i] = init_v[4*i +: 4];
                m_ln[i] = init_v[4*i +: 4];
            end
            m_pend = 0; m_a0 = 0; m_a1 = 0; m_ptr = 0; m_cm = 0; m_nf = 0;
        end else begin
            e0 = req0 && !m_a0;
            e1 = req1 && !m_a1;
            g0 = e0 && (!e1 || !m_ptr);
            g1 = e1 && !g0;
            m_cm = newframe && m_pend;
            if (m_cm) for (int i = 0; i < 8; i++) m_ln[i] = m_sh[i];
            m_pend = (m_pend && !newframe) || g0 || g1;
            if (g0) m_sh[idx0] = code0;
            if (g1) m_sh[idx1] = code1;
            if (e0 && e1) m_ptr = !m_ptr;
            if (newframe && !hold) m_nf++;
            m_a0 = g0;
            m_a1 = g1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("ack0", ack0, m_a0);
        check("ack1", ack1, m_a1);
        check("commit", commit, m_cm);
        check("dirty", dirty, m_pend);
        check("line_out", line_out, disp_line());
        check("value_out", value_out, (m_nf / TICK) % 64);
    endtask

    initial begin
        bit got;
        rst = 0; newframe = 0; hold = 0;
        req0 = 0; idx0 = 0; code0 = 0;
        req1 = 0; idx1 = 0; code1 = 0;

        // Reset
        repeat (3) tick();
        check("rst_line", line_out, 32'hEEDA_EECB);
        check("rst_value", value_out, 0);
        check("rst_flags", {ack0, ack1, commit, dirty}, 4'b0000);
        rst = 1;
        tick();

        // Single write then commit
        req0 = 1; idx0 = 3'd2; code0 = 4'hA;
        tick();
        check("wr_ack0", ack0, 1);
        check("wr_dirty", dirty, 1);
        req0 = 0;
        tick();
        check("wr_line_held", line_out, 32'hEEDA_EECB);
        newframe = 1;
        tick();
        newframe = 0;
        check("commit_line", line_out, 32'hEEDA_EACB);
        check("commit_pulse", commit, 1);
        check("commit_clean", dirty, 0);
        tick();
        check("commit_once", commit, 0);

        // Contention: acks must alternate 0,1,0,1
        req0 = 1; idx0 = 3'd0; code0 = 4'h3;
        req1 = 1; idx1 = 3'd1; code1 = 4'h5;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_ack", {ack0, ack1}, (k % 2 == 0) ? 2'b10 : 2'b01);
        end
        req0 = 0; req1 = 0;
        tick();
        newframe = 1;
        tick();
        newframe = 0;
        check("rr_line", line_out, 32'hEEDA_EA53);

        // Write granted in the same cycle as a DIRTY commit
        req0 = 1; idx0 = 3'd7; code0 = 4'h1;
        tick();
        req0 = 0;
        tick();
        req1 = 1; idx1 = 3'd6; code1 = 4'h2; newframe = 1;
        tick();
        req1 = 0; newframe = 0;
        check("coin_c7", line_out[31:28], 4'h1);
        check("coin_c6", line_out[27:24], 4'hE);
        check("coin_dirty", dirty, 1);
        repeat (2) tick();
        newframe = 1;
        tick();
        newframe = 0;
        check("coin_next", line_out[27:24], 4'h2);

        // Value counter wrap and hold
        rst = 0; tick(); rst = 1; tick();
        for (int p = 1; p <= 128; p++) begin
            newframe = 1; tick(); newframe = 0; tick(); tick();
            if (p == 127) check("val_127", value_out, 63);
        end
        check("val_wrap", value_out, 0);
        hold = 1;
        for (int p = 0; p < 10; p++) begin
            newframe = 1; tick(); newframe = 0; tick(); tick();
        end
        hold = 0;
        check("val_hold", value_out, 0);
        newframe = 1; tick(); newframe = 0; tick();
        check("val_hold_fc", value_out, 0);
        newframe = 1; tick(); newframe = 0; tick();
        check("val_after", value_out, 1);

        // Reset mid-operation with req1 held
        req1 = 1; idx1 = 3'd3; code1 = 4'h7;
        tick();
        check("mid_dirty", dirty, 1);
        rst = 0;
        #2;
        check("rst_sync", dirty, 1);
        tick();
        check("mid_line", line_out, 32'hEEDA_EECB);
        check("mid_clean", dirty, 0);
        tick();
        rst = 1;
        got = 0;
        for (int k = 0; k < 2 && !got; k++) begin
            tick();
            got = ack1;
        end
        check("mid_reack", got, 1);
        req1 = 0;
        tick();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            rst = (c >= 1500 && c < 1502) ? 1'b0 : 1'b1;
            newframe = (c % 23 == 0);
            hold = ($urandom_range(0, 7) == 0);
            if (!req0 || m_a0) begin
                req0 = ($urandom_range(0, 3) != 0);
                idx0 = 3'($urandom);
                code0 = 4'($urandom);
            end
            if (!req1 || m_a1) begin
                req1 = ($urandom_range(0, 3) != 0);
                idx1 = 3'($urandom);
                code1 = 4'($urandom);
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
